fft_butterfly_pipe: RTL and testbench

Three-stage pipelined radix-2 decimation-in-time butterfly for the 16-point FFT datapath. Per transaction it:

- computes the complex twiddle product P = B·W using four Q1.15 real multiplies with the team's fixed-point multiply semantics;
- produces X = A + P and Y = A − P with optional ½ scaling and saturation.

It sits between the stage memory/reorder buffer (upstream, supplies A, B, W) and the stage write-back (downstream). It uses a valid/ready handshake on both sides.

---
 rtl/fft_butterfly_pipe.sv | 128 ++++++++++++
 tb/tb_fft_butterfly_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: X = A + B*W, Y = A - B*W in Q1.15.
// Stage 1 forms four real products, stage 2 the complex product, stage 3 the scaled/saturated sums.
module fft_butterfly_pipe #(
  parameter int unsigned SCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_re,
  input  logic [15:0] a_im,
  input  logic [15:0] b_re,
  input  logic [15:0] b_im,
  input  logic [15:0] w_re,
  input  logic [15:0] w_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x_re,
  output logic [15:0] x_im,
  output logic [15:0] y_re,
  output logic [15:0] y_im,
  output logic        ovf,
  input  logic        ovf_clr
);

  // Q1.15 multiply: bits [30:15] of the full product, so -1 * -1 wraps to 0x8000.
  function automatic logic [15:0] mul(input logic signed [15:0] p, input logic signed [15:0] q);
    logic signed [31:0] prod;
    prod = 32'(p) * 32'(q);
    return prod[30:15];
  endfunction

  // Returns {saturated, value}.
  function automatic logic [16:0] sat_scale(input logic signed [17:0] s);
    logic signed [17:0] t;
    t = (SCALE != 0) ? (s >>> 1) : s;
    if (t > 18'sd32767) begin
      return {1'b1, 16'h7fff};
    end else if (t < -18'sd32768) begin
      return {1'b1, 16'h8000};
    end
    return {1'b0, t[15:0]};
  endfunction

  logic               v1_q, v2_q, v3_q;
  logic        [15:0] mr_q, mi_q, mx_q, my_q;
  logic        [15:0] a1_re_q, a1_im_q, a2_re_q, a2_im_q;
  logic signed [16:0] p_re_q, p_im_q;
  logic signed [16:0] p_re_d, p_im_d;
  logic        [15:0] x_re_q, x_im_q, y_re_q, y_im_q;
  logic        [15:0] x_re_d, x_im_d, y_re_d, y_im_d;
  logic signed [17:0] sx_re, sx_im, sy_re, sy_im;
  logic        [3:0]  sat;
  logic               ovf_q;
  logic               en;

  assign en        = ~v3_q | out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign x_re      = x_re_q;
  assign x_im      = x_im_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;
  assign ovf       = ovf_q;

  always_comb begin
    p_re_d = 17'($signed(mr_q)) - 17'($signed(mi_q));
    p_im_d = 17'($signed(mx_q)) + 17'($signed(my_q));
    sx_re  = 18'($signed(a2_re_q)) + 18'(p_re_q);
    sx_im  = 18'($signed(a2_im_q)) + 18'(p_im_q);
    sy_re  = 18'($signed(a2_re_q)) - 18'(p_re_q);
    sy_im  = 18'($signed(a2_im_q)) - 18'(p_im_q);
    {sat[0], x_re_d} = sat_scale(sx_re);
    {sat[1], x_im_d} = sat_scale(sx_im);
    {sat[2], y_re_d} = sat_scale(sy_re);
    {sat[3], y_im_d} = sat_scale(sy_im);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      mr_q    <= '0;
      mi_q    <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      a1_re_q <= '0;
      a1_im_q <= '0;
      a2_re_q <= '0;
      a2_im_q <= '0;
      p_re_q  <= '0;
      p_im_q  <= '0;
      x_re_q  <= '0;
      x_im_q  <= '0;
      y_re_q  <= '0;
      y_im_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (en) begin
        v1_q    <= in_valid;
        v2_q    <= v1_q;
        v3_q    <= v2_q;
        mr_q    <= mul(b_re, w_re);
        mi_q    <= mul(b_im, w_im);
        mx_q    <= mul(b_re, w_im);
        my_q    <= mul(b_im, w_re);
        a1_re_q <= a_re;
        a1_im_q <= a_im;
        a2_re_q <= a1_re_q;
        a2_im_q <= a1_im_q;
        p_re_q  <= p_re_d;
        p_im_q  <= p_im_d;
        x_re_q  <= x_re_d;
        x_im_q  <= x_im_d;
        y_re_q  <= y_re_d;
        y_im_q  <= y_im_d;
      end
      // Only real transactions raise the flag; bubble slots carry stale data.
      if (en && v2_q && (|sat)) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Bench for fft_butterfly_pipe: SCALE=1 and SCALE=0 instances share stimulus; a queue of
// model results is pushed on input transfer and compared on output transfer.
module tb_fft_butterfly_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, ovf_clr;
  logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic        ir1, ov1, ovf1, ir0, ov0, ovf0;
  logic [15:0] x1_re, x1_im, y1_re, y1_im, x0_re, x0_im, y0_re, y0_im;

  always #5 clk = ~clk;

  fft_butterfly_pipe #(.SCALE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(ov1), .out_ready(out_ready),
    .x_re(x1_re), .x_im(x1_im), .y_re(y1_re), .y_im(y1_im), .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  fft_butterfly_pipe #(.SCALE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(ov0), .out_ready(out_ready),
    .x_re(x0_re), .x_im(x0_im), .y_re(y0_re), .y_im(y0_im), .ovf(ovf0), .ovf_clr(ovf_clr)
  );

  typedef struct packed {
    logic [63:0] r1;
    logic [63:0] r0;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] hold1, hold0, last1, last0;

  function automatic logic [15:0] m_mul(input logic [15:0] p, input logic [15:0] q);
    int ip, iq, pr;
    ip = $signed(p);
    iq = $signed(q);
    pr = (ip * iq) >>> 15;
    return pr[15:0];
  endfunction

  function automatic logic [15:0] m_clip(input int s, input bit scale);
    int t;
    t = scale ? (s >>> 1) : s;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t[15:0];
  endfunction

  function automatic logic [63:0] model(input logic [15:0] ar, ai, br, bi, wr, wi,
                                        input bit scale);
    int pr, pi, xa, xb;
    pr = int'($signed(m_mul(br, wr))) - int'($signed(m_mul(bi, wi)));
    pi = int'($signed(m_mul(br, wi))) + int'($signed(m_mul(bi, wr)));
    xa = $signed(ar);
    xb = $signed(ai);
    return {m_clip(xa + pr, scale), m_clip(xb + pi, scale),
            m_clip(xa - pr, scale), m_clip(xb - pi, scale)};
  endfunction

  // One clock: observe at the falling edge, return 1 ns after the rising edge.
  task automatic step(output bit acc, output bit got);
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    got = 1'b0;
    if (rst_n) begin
      checks++;
      if (ir1 !== (~ov1 | out_ready) || ir0 !== ir1 || ov0 !== ov1) begin
        errors++;
        $display("FAIL handshake in_ready=%b/%b out_valid=%b/%b out_ready=%b",
                 ir1, ir0, ov1, ov0, out_ready);
      end
      if (stall_prev) begin
        checks++;
        if ({x1_re, x1_im, y1_re, y1_im} !== hold1 || {x0_re, x0_im, y0_re, y0_im} !== hold0) begin
          errors++;
          $display("FAIL stall_hold got %h %h want %h %h", {x1_re, x1_im, y1_re, y1_im},
                   {x0_re, x0_im, y0_re, y0_im}, hold1, hold0);
        end
      end
      if (in_valid && ir1) begin
        sb.push_back({model(a_re, a_im, b_re, b_im, w_re, w_im, 1'b1),
                      model(a_re, a_im, b_re, b_im, w_re, w_im, 1'b0)});
        acc = 1'b1;
      end
      if (ov1 && out_ready) begin
        got   = 1'b1;
        last1 = {x1_re, x1_im, y1_re, y1_im};
        last0 = {x0_re, x0_im, y0_re, y0_im};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h %h want none", last1, last0);
        end else begin
          e = sb.pop_front();
          if (last1 !== e.r1 || last0 !== e.r0) begin
            errors++;
            $display("FAIL scoreboard got %h %h want %h %h", last1, last0, e.r1, e.r0);
          end
        end
      end
      stall_prev = ov1 && !out_ready;
      hold1 = {x1_re, x1_im, y1_re, y1_im};
      hold0 = {x0_re, x0_im, y0_re, y0_im};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_wait(input logic [15:0] ar, ai, br, bi, wr, wi,
                           output bit got, output int lat);
    bit acc, go;
    {a_re, a_im, b_re, b_im, w_re, w_im} = {ar, ai, br, bi, wr, wi};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    got = 1'b0;
    lat = 0;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(acc, go);
    in_valid = 1'b0;
    if (!acc) return;
    for (int i = 0; i < 10 && !got; i++) begin
      step(acc, go);
      lat++;
      got = go;
    end
  endtask

  task automatic test_reset();
    bit acc, go;
    step(acc, go);
    checks++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || ovf1 !== 1'b0 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ir=%b ov=%b ovf=%b%b want 1 0 00", ir1, ov1, ovf1, ovf0);
    end
    checks++;
    if ({x1_re, x1_im, y1_re, y1_im, x0_re, x0_im, y0_re, y0_im} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h want 0", {x1_re, x1_im, y1_re, y1_im},
               {x0_re, x0_im, y0_re, y0_im});
    end
  endtask

  task automatic test_unity();
    bit got;
    int lat;
    send_wait(16'h2000, 16'h0, 16'h4000, 16'h0, 16'h7fff, 16'h0, got, lat);
    checks++;
    if (!got || lat != 3) begin
      errors++;
      $display("FAIL unity_latency got %0d (seen=%b) want 3", lat, got);
    end
    checks++;
    if (last1 !== {16'h2fff, 16'h0000, 16'hf000, 16'h0000}) begin
      errors++;
      $display("FAIL unity_value got %h want 2fff0000f0000000", last1);
    end
    checks++;
    if (ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL unity_ovf got %b want 0", ovf1);
    end
  endtask

  task automatic test_minus_j();
    bit got;
    int lat;
    send_wait(16'h0, 16'h0, 16'h4000, 16'h0, 16'h0, 16'h8000, got, lat);
    checks++;
    if (!got || last1 !== {16'h0000, 16'he000, 16'h0000, 16'h2000}) begin
      errors++;
      $display("FAIL minus_j got %h (seen=%b) want 0000e00000002000", last1, got);
    end
  endtask

  task automatic test_saturation();
    bit got, acc, go;
    int lat;
    ovf_clr = 1'b1;
    step(acc, go);
    ovf_clr = 1'b0;
    checks++;
    if (ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL sat_preclear got %b want 0", ovf0);
    end
    send_wait(16'h7fff, 16'h0, 16'h7fff, 16'h0, 16'h7fff, 16'h0, got, lat);
    checks++;
    if (!got || last0 !== {16'h7fff, 16'h0000, 16'h0001, 16'h0000}) begin
      errors++;
      $display("FAIL sat_value got %h (seen=%b) want 7fff000000010000", last0, got);
    end
    checks++;
    if (ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL sat_ovf_set got %b want 1", ovf0);
    end
    repeat (3) step(acc, go);
    checks++;
    if (ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL sat_ovf_sticky got %b want 1", ovf0);
    end
    ovf_clr = 1'b1;
    step(acc, go);
    ovf_clr = 1'b0;
    checks++;
    if (ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL sat_ovf_clear got %b want 0", ovf0);
    end
  endtask

  task automatic test_product_wrap();
    bit got;
    int lat;
    send_wait(16'h0, 16'h0, 16'h8000, 16'h0, 16'h8000, 16'h0, got, lat);
    checks++;
    if (!got || last1 !== {16'hc000, 16'h0000, 16'h4000, 16'h0000}) begin
      errors++;
      $display("FAIL wrap got %h (seen=%b) want c000000040000000", last1, got);
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] vec[16];
    int idx, cyc, nout;
    bit acc, go;
    for (int i = 0; i < 16; i++) vec[i] = {$urandom, $urandom, $urandom};
    vec[0] = {16'h8000, 16'h8000, 16'h7fff, 16'h8000, 16'h8000, 16'h7fff};
    idx = 0;
    cyc = 0;
    nout = 0;
    while (idx < 16 && cyc < 300) begin
      out_ready = ((cyc >= 3 && cyc < 8) || (cyc >= 14 && cyc < 19)) ? 1'b0
                                                                     : 1'($urandom_range(0, 1));
      {a_re, a_im, b_re, b_im, w_re, w_im} = vec[idx];
      in_valid = 1'b1;
      step(acc, go);
      if (acc) idx++;
      if (go) nout++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      step(acc, go);
      if (go) nout++;
    end
    checks++;
    if (idx != 16 || nout != 16 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_count got in=%0d out=%0d left=%0d want 16 16 0", idx, nout, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    bit acc, go, got;
    int lat, n;
    logic [63:0] want;
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && n < 3; i++) begin
      {a_re, a_im, b_re, b_im, w_re, w_im} = {$urandom, $urandom, $urandom};
      in_valid = 1'b1;
      step(acc, go);
      if (acc) n++;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov1 !== 1'b0 || {x1_re, x1_im, y1_re, y1_im, x0_re, x0_im, y0_re, y0_im} !== 128'h0) begin
      errors++;
      $display("FAIL midreset_clear got ov=%b x=%h want 0 0", ov1, {x1_re, x1_im, y1_re, y1_im});
    end
    sb.delete();
    stall_prev = 1'b0;
    #2;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(acc, go);
      if (go || ov1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL midreset_stale got %0d outputs want 0", n);
    end
    want = model(16'h1234, 16'hfedc, 16'h4000, 16'hc000, 16'h5a82, 16'ha57e, 1'b1);
    send_wait(16'h1234, 16'hfedc, 16'h4000, 16'hc000, 16'h5a82, 16'ha57e, got, lat);
    checks++;
    if (!got || lat != 3 || last1 !== want) begin
      errors++;
      $display("FAIL midreset_next got %h lat=%0d want %h lat=3", last1, lat, want);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    {a_re, a_im, b_re, b_im, w_re, w_im} = '0;
    #17;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_unity();
    test_minus_j();
    test_saturation();
    test_product_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
